softmax_sched: RTL and testbench

Round-robin scheduler that shares one `softmax_vec` engine between `NUM_REQ` requester streams, e.g. the attention heads of a transformer layer. It works on one row at a time. For each row it grants one requester, starts and feeds the engine, and routes the engine's output tiles back with the requester's ID. It then resets the engine and moves to the next requester. It sits between the per-head score buffers and the engine, and owns the engine's `en`, `start` and reset pins.

---
 rtl/softmax_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_softmax_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_sched.sv
// Purpose : round-robin scheduler sharing one softmax_vec engine between NUM_REQ
//           requesters, one row at a time; owns the engine's en/start/reset pins.
// Latency : req->gnt/eng_start 1 cycle, in_ready 2 cycles; tile in->engine 1 cycle;
//           engine out->out_tile 1 cycle; eng_done->row_done 1 cycle, IDLE 2 cycles.
// Backpressure: in_ready is the granted bit only while feeding; out_tile has none.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req                   per-requester row request (level)
//   in_tile/in_valid      per-requester tile bus (requester r at slice r*TW)
//   in_ready              tile accept, granted requester only, during FEED
//   gnt                   one-hot grant held for the whole row
//   eng_en/eng_start      engine enable (START..WAIT) and one-cycle start pulse
//   eng_rst_n             registered engine reset, low in reset and one cycle per row
//   eng_tile_in(_valid)   registered tile towards the engine
//   eng_tile_out(_valid)  tile from the engine, eng_done ends the row
//   out_tile/out_valid/out_id  forwarded result tile tagged with owning requester
//   row_done/row_id/row_err    end-of-row pulse, owner, abort/bad-count flag
//   busy                  scheduler not idle
module softmax_sched #(
  parameter int WIDTH          = 32,
  parameter int TILE_SIZE      = 8,
  parameter int TOTAL_ELEMENTS = 64,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT        = 4096,
  localparam int TILES = (TOTAL_ELEMENTS + TILE_SIZE - 1) / TILE_SIZE,
  localparam int IDW   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int TW    = TILE_SIZE * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*TW-1:0] in_tile,
  input  logic [NUM_REQ-1:0]    in_valid,
  output logic [NUM_REQ-1:0]    in_ready,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  eng_en,
  output logic                  eng_start,
  output logic                  eng_rst_n,
  output logic [TW-1:0]         eng_tile_in,
  output logic                  eng_tile_in_valid,
  input  logic [TW-1:0]         eng_tile_out,
  input  logic                  eng_tile_out_valid,
  input  logic                  eng_done,
  output logic [TW-1:0]         out_tile,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic                  row_done,
  output logic [IDW-1:0]        row_id,
  output logic                  row_err,
  output logic                  busy
);

  localparam int CW = $clog2(TILES + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        tiles_in_q, tiles_in_d;
  logic [CW-1:0]        tiles_out_q, tiles_out_d;
  logic [WW-1:0]        wd_cnt_q, wd_cnt_d;
  logic                 row_err_q, row_err_d;
  logic [TW-1:0]        eng_tile_in_q;
  logic                 eng_tile_in_valid_q;
  logic [TW-1:0]        out_tile_q;
  logic                 out_valid_q;
  logic [IDW-1:0]       out_id_q;
  logic                 eng_rst_n_q;

  logic                 arb_found;
  logic [IDW-1:0]       arb_id;
  logic                 xfer;
  logic                 last_in;
  logic                 fwd;
  logic [CW:0]          out_sum;
  logic                 cnt_ok;
  logic                 wd_expired;

  // Round-robin pick: first set req bit scanning upward from rr_ptr+1, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!arb_found && req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_id    = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign xfer       = (state_q == S_FEED) && in_valid[gnt_id_q];
  assign last_in    = xfer && (tiles_in_q == CW'(TILES - 1));
  // Result path is open in FEED as well as WAIT; the engine just never emits in FEED.
  assign fwd        = eng_tile_out_valid && ((state_q == S_FEED) || (state_q == S_WAIT));
  // Tile count check includes a tile arriving in the same cycle as eng_done.
  assign out_sum    = {1'b0, tiles_out_q} + {{CW{1'b0}}, eng_tile_out_valid};
  assign cnt_ok     = (out_sum == (CW + 1)'(TILES));
  assign wd_expired = (wd_cnt_q == WW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_found) state_d = S_START;
      S_START: state_d = S_FEED;
      S_FEED:  if (last_in) state_d = S_WAIT;
      S_WAIT:  if (eng_done || wd_expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = '0;
    if (state_q == S_FEED) in_ready[gnt_id_q] = 1'b1;
    eng_start = (state_q == S_START);
    eng_en    = (state_q == S_START) || (state_q == S_FEED) || (state_q == S_WAIT);
    row_done  = (state_q == S_DONE);
    row_id    = row_done ? gnt_id_q : '0;
    row_err   = row_done && row_err_q;
    busy      = (state_q != S_IDLE);
  end

  assign gnt               = gnt_q;
  assign eng_rst_n         = eng_rst_n_q;
  assign eng_tile_in       = eng_tile_in_q;
  assign eng_tile_in_valid = eng_tile_in_valid_q;
  assign out_tile          = out_tile_q;
  assign out_valid         = out_valid_q;
  assign out_id            = out_id_q;

  // Datapath next-state: grant, pointer, per-row counters, error flag.
  always_comb begin
    gnt_id_d    = gnt_id_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    tiles_in_d  = tiles_in_q;
    tiles_out_d = tiles_out_q;
    wd_cnt_d    = wd_cnt_q;
    row_err_d   = row_err_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_id_d        = arb_id;
          gnt_d           = '0;
          gnt_d[arb_id]   = 1'b1;
        end
      end
      S_START: begin
        tiles_in_d  = '0;
        tiles_out_d = '0;
        wd_cnt_d    = '0;
        row_err_d   = 1'b0;
      end
      S_FEED: begin
        if (xfer) tiles_in_d = tiles_in_q + CW'(1);
      end
      S_WAIT: begin
        if (!wd_expired) wd_cnt_d = wd_cnt_q + WW'(1);
        if (eng_done)        row_err_d = !cnt_ok;
        else if (wd_expired) row_err_d = 1'b1;
      end
      S_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = gnt_id_q;
      end
      default: ;
    endcase
    // Saturate so a misbehaving engine cannot wrap the count back to TILES.
    if (fwd && (tiles_out_q != {CW{1'b1}})) tiles_out_d = tiles_out_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_id_q            <= '0;
      gnt_q               <= '0;
      rr_ptr_q            <= IDW'(NUM_REQ - 1);
      tiles_in_q          <= '0;
      tiles_out_q         <= '0;
      wd_cnt_q            <= '0;
      row_err_q           <= 1'b0;
      eng_tile_in_q       <= '0;
      eng_tile_in_valid_q <= 1'b0;
      out_tile_q          <= '0;
      out_valid_q         <= 1'b0;
      out_id_q            <= '0;
      eng_rst_n_q         <= 1'b0;
    end else begin
      gnt_id_q            <= gnt_id_d;
      gnt_q               <= gnt_d;
      rr_ptr_q            <= rr_ptr_d;
      tiles_in_q          <= tiles_in_d;
      tiles_out_q         <= tiles_out_d;
      wd_cnt_q            <= wd_cnt_d;
      row_err_q           <= row_err_d;
      eng_tile_in_valid_q <= xfer;
      if (xfer) eng_tile_in_q <= in_tile[gnt_id_q*TW +: TW];
      out_valid_q         <= fwd;
      if (fwd) begin
        out_tile_q <= eng_tile_out;
        out_id_q   <= gnt_id_q;
      end
      // Registered from state_d so the engine sees reset in the DONE cycle itself.
      eng_rst_n_q         <= (state_d != S_DONE);
    end
  end

endmodule

// File: tb/tb_softmax_sched.sv
module tb_softmax_sched;

  localparam int WIDTH          = 32;
  localparam int TILE_SIZE      = 8;
  localparam int TOTAL_ELEMENTS = 64;
  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT        = 4096;
  localparam int TILES          = 8;
  localparam int IDW            = 2;
  localparam int TW             = TILE_SIZE * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*TW-1:0] in_tile;
  logic [NUM_REQ-1:0]    in_valid;
  logic [NUM_REQ-1:0]    in_ready;
  logic [NUM_REQ-1:0]    gnt;
  logic                  eng_en;
  logic                  eng_start;
  logic                  eng_rst_n;
  logic [TW-1:0]         eng_tile_in;
  logic                  eng_tile_in_valid;
  logic [TW-1:0]         eng_tile_out;
  logic                  eng_tile_out_valid;
  logic                  eng_done;
  logic [TW-1:0]         out_tile;
  logic                  out_valid;
  logic [IDW-1:0]        out_id;
  logic                  row_done;
  logic [IDW-1:0]        row_id;
  logic                  row_err;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  softmax_sched #(
    .WIDTH(WIDTH), .TILE_SIZE(TILE_SIZE), .TOTAL_ELEMENTS(TOTAL_ELEMENTS),
    .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_tile(in_tile), .in_valid(in_valid),
    .in_ready(in_ready), .gnt(gnt), .eng_en(eng_en), .eng_start(eng_start),
    .eng_rst_n(eng_rst_n), .eng_tile_in(eng_tile_in), .eng_tile_in_valid(eng_tile_in_valid),
    .eng_tile_out(eng_tile_out), .eng_tile_out_valid(eng_tile_out_valid),
    .eng_done(eng_done), .out_tile(out_tile), .out_valid(out_valid), .out_id(out_id),
    .row_done(row_done), .row_id(row_id), .row_err(row_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input tile of requester r, tile k: element e = {r, k, e}.
  function automatic logic [TW-1:0] mk_tile(input int r, input int k);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < TILE_SIZE; e++) t[e*WIDTH +: WIDTH] = WIDTH'((r << 16) | (k << 8) | e);
    return t;
  endfunction

  function automatic logic [TW-1:0] res_tile(input int k);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < TILE_SIZE; e++) t[e*WIDTH +: WIDTH] = 32'hA000_0000 | WIDTH'((k << 8) | e);
    return t;
  endfunction

  task automatic idle_inputs();
    req                = '0;
    in_valid           = '0;
    in_tile            = '0;
    eng_tile_out       = '0;
    eng_tile_out_valid = 1'b0;
    eng_done           = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_eng_en", eng_en, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_tin_vld", eng_tile_in_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_eng_rst_n", eng_rst_n, 1);
  endtask

  // Wait for grant of requester id, check START, then feed n_feed tiles.
  task automatic start_and_feed(input int id, input int gaps, input int noise_r,
                                input int n_feed, input bit drop);
    logic [NUM_REQ-1:0] oh;
    int g, sent, cyc;
    logic vld;
    oh = '0;
    oh[id] = 1'b1;
    g = 0;
    while (gnt == '0 && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (drop) req = '0;
    chk("gnt", gnt, oh);
    chk("start_on", eng_start, 1);
    chk("en_start", eng_en, 1);
    chk("busy_start", busy, 1);
    chk("rdy_start", in_ready, 0);
    @(negedge clk);
    chk("start_off", eng_start, 0);
    chk("rdy_feed", in_ready, oh);
    sent = 0;
    cyc  = 0;
    while (sent < n_feed && cyc < 4 * TILES) begin
      vld = (gaps == 0) || (cyc % 2 == 0);
      in_valid = '0;
      in_valid[id] = vld;
      in_tile[id*TW +: TW] = mk_tile(id, sent);
      if (noise_r >= 0) begin
        in_valid[noise_r] = 1'b1;
        in_tile[noise_r*TW +: TW] = mk_tile(noise_r, 15);
      end
      @(negedge clk);
      cyc++;
      chk("tin_vld", eng_tile_in_valid, vld);
      if (vld) begin
        chk("tin_dat", eng_tile_in, mk_tile(id, sent));
        sent++;
      end
      if (noise_r >= 0) chk("noise_rdy", in_ready[noise_r], 0);
    end
    in_valid = '0;
    chk("feed_cnt", sent, n_feed);
  endtask

  task automatic serve_row(input int id, input int gaps, input int noise_r,
                           input int n_out, input bit dwl, input bit drop);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    start_and_feed(id, gaps, noise_r, TILES, drop);
    chk("rdy_drop", in_ready, 0);
    chk("en_wait", eng_en, 1);
    for (int k = 0; k < n_out; k++) begin
      eng_tile_out_valid = 1'b1;
      eng_tile_out       = res_tile(k);
      eng_done           = dwl && (k == n_out - 1);
      @(negedge clk);
      chk("out_vld", out_valid, 1);
      chk("out_id", out_id, id);
      chk("out_dat", out_tile, res_tile(k));
    end
    eng_tile_out_valid = 1'b0;
    eng_tile_out       = '0;
    if (!dwl) begin
      eng_done = 1'b1;
      @(negedge clk);
      chk("out_idle", out_valid, 0);
    end
    eng_done = 1'b0;
    chk("row_done", row_done, 1);
    chk("row_id", row_id, id);
    chk("row_err", row_err, (n_out != TILES));
    chk("eng_rst_lo", eng_rst_n, 0);
    chk("en_done", eng_en, 0);
    chk("gnt_done", gnt, oh);
    @(negedge clk);
    chk("row_done_off", row_done, 0);
    chk("eng_rst_hi", eng_rst_n, 1);
    chk("busy_idle", busy, 0);
    chk("gnt_idle", gnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    idle_inputs();
    do_reset();

    // Single requester 2, back-to-back tiles, clean row.
    req = 4'b0100;
    serve_row(2, 0, -1, TILES, 1'b0, 1'b1);

    // Fresh pointer (3): req 1001 wraps to 0, then 3.
    do_reset();
    req = 4'b1001;
    serve_row(0, 0, -1, TILES, 1'b0, 1'b0);
    serve_row(3, 0, -1, TILES, 1'b0, 1'b0);

    // All requesting, pointer at 3: 0,1,2,3,0.
    req = 4'b1111;
    serve_row(0, 0, -1, TILES, 1'b0, 1'b0);
    serve_row(1, 0, -1, TILES, 1'b0, 1'b0);
    serve_row(2, 0, -1, TILES, 1'b0, 1'b0);
    serve_row(3, 0, -1, TILES, 1'b0, 1'b0);
    serve_row(0, 0, -1, TILES, 1'b0, 1'b0);
    req = '0;

    // Gapped valid on requester 1 with requester 3 driving noise; last tile with done.
    req = 4'b0010;
    serve_row(1, 1, 3, TILES, 1'b1, 1'b1);

    // Engine returns only 7 tiles: row_err.
    req = 4'b0100;
    serve_row(2, 0, -1, TILES - 1, 1'b0, 1'b1);

    // Engine never finishes: timeout exactly TIMEOUT cycles after WAIT entry.
    req = 4'b0001;
    start_and_feed(0, 0, -1, TILES, 1'b1);
    chk("to_rdy_drop", in_ready, 0);
    n = 0;
    while (!row_done && n < TIMEOUT + 16) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TIMEOUT);
    chk("to_row_err", row_err, 1);
    chk("to_row_id", row_id, 0);
    chk("to_eng_rst", eng_rst_n, 0);
    @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_gnt", gnt, 0);
    chk("to_row_done_off", row_done, 0);

    // Reset mid-FEED after 3 tiles; pointer returns to 3 so 0 wins.
    req = 4'b0010;
    start_and_feed(1, 0, -1, 3, 1'b0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("mid_busy_rst", busy, 0);
    chk("mid_gnt", gnt, 0);
    chk("mid_rdy", in_ready, 0);
    chk("mid_en", eng_en, 0);
    chk("mid_tin_vld", eng_tile_in_valid, 0);
    chk("mid_tin", eng_tile_in, 0);
    chk("mid_row_done", row_done, 0);
    chk("mid_eng_rst", eng_rst_n, 0);
    rst_n = 1'b1;
    serve_row(0, 0, -1, TILES, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
